// File: rtl/hi_lo_pkg.sv
// Shared definitions for the Hi/Lo multiply/divide unit: default operand
// width, operation encodings, control-state encoding and small op-decode
// helpers used by the control logic.
package hi_lo_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MADD  = 3'b100,
        OP_MSUB  = 3'b101,
        OP_MTHI  = 3'b110,
        OP_MTLO  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Ops whose operands are two's complement (magnitudes taken on entry).
    function automatic logic op_is_signed(op_e op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

    function automatic logic op_is_div(op_e op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    // Single-cycle register moves that never enter the iterative path.
    function automatic logic op_is_move(op_e op);
        return op inside {OP_MTHI, OP_MTLO};
    endfunction

endpackage

// File: rtl/hi_lo_muldiv_unit_if.sv
// Request/response bundle of the Hi/Lo multiply/divide unit.
//   master : requester side (drives Start/Op/OperandA/OperandB/Flush,
//            observes Busy/Done/DivByZero/Hi/Lo)
//   slave  : the unit itself
interface hi_lo_muldiv_unit_if #(
    parameter int WIDTH = hi_lo_pkg::DEFAULT_WIDTH
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic             Flush;
    logic             Busy;
    logic             Done;
    logic             DivByZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, OperandA, OperandB, Flush,
        input  Busy, Done, DivByZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, OperandA, OperandB, Flush,
        output Busy, Done, DivByZero, Hi, Lo
    );
endinterface

// File: rtl/hi_lo_iter_core.sv
// Bit-serial datapath of the Hi/Lo unit. Works on unsigned magnitudes only;
// sign handling lives in the control block.
//   Clk, Reset : clock, async active-low reset
//   load       : capture load_a (multiplier / dividend) and load_b
//                (multiplicand / divisor), clear the accumulator
//   step       : perform one iteration (shift-add or restoring-divide step)
//   div_mode   : 1 = divide step, 0 = multiply step
//   acc, q     : multiply -> {acc,q} is the product;
//                divide   -> q is the quotient, acc the remainder
module hi_lo_iter_core
    import hi_lo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] load_a,
    input  logic [WIDTH-1:0] load_b,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] acc_r, q_r, m_r;
    logic [WIDTH:0]   sum, shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Multiply: add multiplicand when the multiplier LSB is set, then shift
    // the {carry,acc,q} pair right by one; product bits fill q from the top.
    assign sum = {1'b0, acc_r} + (q_r[0] ? {1'b0, m_r} : '0);

    // Restoring divide: shift the next dividend bit into the partial
    // remainder; remainder < divisor before the shift, so the trial
    // difference always fits back in WIDTH bits when it is kept.
    assign shifted = {acc_r, q_r[WIDTH-1]};
    assign fits    = shifted >= {1'b0, m_r};
    assign diff    = shifted[WIDTH-1:0] - m_r;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            acc_r <= '0;
            q_r   <= '0;
            m_r   <= '0;
        end else if (load) begin
            acc_r <= '0;
            q_r   <= load_a;
            m_r   <= load_b;
        end else if (step) begin
            if (div_mode) begin
                acc_r <= fits ? diff : shifted[WIDTH-1:0];
                q_r   <= {q_r[WIDTH-2:0], fits};
            end else begin
                acc_r <= sum[WIDTH:1];
                q_r   <= {sum[0], q_r[WIDTH-1:1]};
            end
        end
    end

    assign acc = acc_r;
    assign q   = q_r;

endmodule

// File: rtl/hi_lo_muldiv_unit.sv
// Hi/Lo multiply/divide unit: MULT/MULTU/DIV/DIVU/MADD/MSUB run WIDTH
// iterations in hi_lo_iter_core followed by a sign-fix/writeback cycle;
// MTHI/MTLO and divide-by-zero complete in the accepting cycle.
//   Clk, Reset : clock, async active-low reset
//   bus        : slave side of hi_lo_muldiv_unit_if
//                (Start/Op/OperandA/OperandB/Flush in,
//                 Busy/Done/DivByZero/Hi/Lo out)
module hi_lo_muldiv_unit
    import hi_lo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               Clk,
    input  logic               Reset,
    hi_lo_muldiv_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state, state_next;
    logic [CNT_W-1:0]   cnt;
    op_e                op_in, op_r;
    logic               in_signed;
    logic               neg_quo;   // product / quotient must be negated
    logic               neg_rem;   // remainder takes the dividend's sign
    logic               accept_iter, step, wr_fix, wr_move, wr_dz;
    logic [WIDTH-1:0]   a_mag, b_mag, core_acc, core_q;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               done_r, dz_r;
    logic [2*WIDTH-1:0] prod, prod_s, hilo, fix_val;

    assign op_in     = op_e'(bus.Op);
    assign in_signed = op_is_signed(op_in);

    // Most-negative input maps onto itself, which is the correct unsigned
    // magnitude 2^(WIDTH-1).
    assign a_mag = (in_signed && bus.OperandA[WIDTH-1]) ? -bus.OperandA : bus.OperandA;
    assign b_mag = (in_signed && bus.OperandB[WIDTH-1]) ? -bus.OperandB : bus.OperandB;

    // ---------------- control FSM ----------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        accept_iter = 1'b0;
        step        = 1'b0;
        wr_fix      = 1'b0;
        wr_move     = 1'b0;
        wr_dz       = 1'b0;
        case (state)
            S_IDLE: begin
                // Flush wins over a coincident Start.
                if (bus.Start && !bus.Flush) begin
                    if (op_is_move(op_in)) begin
                        wr_move = 1'b1;
                    end else if (op_is_div(op_in) && bus.OperandB == '0) begin
                        wr_dz = 1'b1;
                    end else begin
                        accept_iter = 1'b1;
                        state_next  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.Flush) begin
                    state_next = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == '0) state_next = S_FIX;
                end
            end
            S_FIX: begin
                wr_fix     = !bus.Flush;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Loaded with WIDTH-1 so the RUN phase covers exactly WIDTH steps.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)                  cnt <= '0;
        else if (accept_iter)        cnt <= CNT_W'(WIDTH - 1);
        else if (step && cnt != '0)  cnt <= cnt - CNT_W'(1);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            op_r    <= OP_MULT;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (accept_iter) begin
            op_r    <= op_in;
            neg_quo <= in_signed & (bus.OperandA[WIDTH-1] ^ bus.OperandB[WIDTH-1]);
            neg_rem <= in_signed & bus.OperandA[WIDTH-1];
        end
    end

    // ---------------- datapath ----------------
    hi_lo_iter_core #(.WIDTH(WIDTH)) u_core (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (accept_iter),
        .step     (step),
        .div_mode (op_is_div(op_r)),
        .load_a   (a_mag),
        .load_b   (b_mag),
        .acc      (core_acc),
        .q        (core_q)
    );

    // Sign fix and accumulate, evaluated during the FIX cycle.
    assign prod   = {core_acc, core_q};
    assign prod_s = neg_quo ? -prod : prod;
    assign hilo   = {hi_r, lo_r};

    always_comb begin
        fix_val = prod_s;
        case (op_r)
            OP_MADD:         fix_val = hilo + prod_s;
            OP_MSUB:         fix_val = hilo - prod_s;
            OP_DIV, OP_DIVU: fix_val = {neg_rem ? -core_acc : core_acc,
                                        neg_quo ? -core_q   : core_q};
            default:         fix_val = prod_s;
        endcase
    end

    // ---------------- architectural Hi/Lo ----------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (wr_fix) begin
            {hi_r, lo_r} <= fix_val;
        end else if (wr_move) begin
            if (op_in == OP_MTHI) hi_r <= bus.OperandA;
            else                  lo_r <= bus.OperandA;
        end else if (wr_dz) begin
            hi_r <= bus.OperandA;
            lo_r <= '1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            done_r <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            done_r <= wr_fix | wr_move | wr_dz;
            dz_r   <= wr_dz;
        end
    end

    assign bus.Busy      = (state != S_IDLE);
    assign bus.Done      = done_r;
    assign bus.DivByZero = dz_r;
    assign bus.Hi        = hi_r;
    assign bus.Lo        = lo_r;

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Self-checking bench for hi_lo_muldiv_unit at WIDTH=32: directed vectors,
// randomized ops against a plain-arithmetic Hi/Lo model, flush and reset.
module tb_hi_lo_muldiv_unit;
    import hi_lo_pkg::*;

    localparam int W = 32;

    logic Clk;
    logic Reset;
    int   checks = 0;
    int   passed = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] corners [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    hi_lo_muldiv_unit_if #(.WIDTH(W)) bus ();

    hi_lo_muldiv_unit #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {Hi,Lo} updated with native wide arithmetic.
    task automatic model_op(input logic [2:0] op, input logic [W-1:0] a, b,
                            output logic [W-1:0] ehi, elo, output logic edz,
                            output int elat);
        logic [63:0] hl;
        longint sa, sb, q, r;
        hl = {m_hi, m_lo};
        edz = 1'b0;
        elat = W + 1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT:  hl = sa * sb;
            OP_MULTU: hl = {32'b0, a} * {32'b0, b};
            OP_MADD:  hl = hl + (sa * sb);
            OP_MSUB:  hl = hl - (sa * sb);
            OP_MTHI:  begin hl[63:32] = a; elat = 0; end
            OP_MTLO:  begin hl[31:0] = a; elat = 0; end
            default: begin
                if (b == 0) begin
                    hl = {a, 32'hFFFFFFFF}; edz = 1'b1; elat = 0;
                end else if (op == OP_DIV) begin
                    q = sa / sb; r = sa % sb;
                    hl = {r[31:0], q[31:0]};
                end else begin
                    hl = {a % b, a / b};
                end
            end
        endcase
        m_hi = hl[63:32];
        m_lo = hl[31:0];
        ehi = m_hi;
        elo = m_lo;
    endtask

    // Issues an op in the current cycle (caller sits at a negedge) and returns
    // at the negedge where Done is seen, or after a 100-cycle bound.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b,
                          output logic [W-1:0] hi, lo, output logic dz,
                          output int lat, output int busy_n);
        bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
        @(negedge Clk);
        bus.Start = 1'b0;
        bus.Op = 3'($urandom); bus.OperandA = $urandom; bus.OperandB = $urandom;
        lat = 0;
        busy_n = 0;
        while (bus.Done !== 1'b1 && lat < 100) begin
            if (bus.Busy === 1'b1) busy_n++;
            @(negedge Clk);
            lat++;
        end
        hi = bus.Hi; lo = bus.Lo; dz = bus.DivByZero;
    endtask

    function automatic logic [W-1:0] pick();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checks++; if (bus.Busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.Busy); else passed++;
        checks++; if (bus.Done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.Done); else passed++;
        checks++; if (bus.DivByZero !== 1'b0) $display("FAIL reset_dz got %b exp 0", bus.DivByZero); else passed++;
        checks++; if (bus.Hi !== 32'h0) $display("FAIL reset_hi got %h exp 0", bus.Hi); else passed++;
        checks++; if (bus.Lo !== 32'h0) $display("FAIL reset_lo got %h exp 0", bus.Lo); else passed++;
        Reset = 1'b1;
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_mult();
        logic [W-1:0] hi, lo, eh, el; logic dz, edz; int lat, bn, el_n;
        model_op(OP_MULT, 32'hFFFFFFFD, 32'd7, eh, el, edz, el_n);
        run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, hi, lo, dz, lat, bn);
        checks++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi got %h exp ffffffff", hi); else passed++;
        checks++; if (lo !== 32'hFFFFFFEB) $display("FAIL mult_lo got %h exp ffffffeb", lo); else passed++;
        checks++; if (lat !== 33) $display("FAIL mult_latency got %0d exp 33", lat); else passed++;
        checks++; if (bn !== 33) $display("FAIL mult_busy_cycles got %0d exp 33", bn); else passed++;
        checks++; if (bus.Busy !== 1'b0) $display("FAIL mult_busy_at_done got %b exp 0", bus.Busy); else passed++;
        @(negedge Clk);
        checks++; if (bus.Done !== 1'b0) $display("FAIL mult_done_width got %b exp 0", bus.Done); else passed++;
    endtask

    task automatic test_div();
        logic [W-1:0] hi, lo, eh, el; logic dz, edz; int lat, bn, el_n;
        model_op(OP_DIVU, 32'd100, 32'd7, eh, el, edz, el_n);
        run_op(OP_DIVU, 32'd100, 32'd7, hi, lo, dz, lat, bn);
        checks++; if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL divu got hi=%h lo=%h exp hi=2 lo=e", hi, lo); else passed++;
        model_op(OP_DIV, 32'hFFFFFFF9, 32'd2, eh, el, edz, el_n);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, hi, lo, dz, lat, bn);
        checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) $display("FAIL div_neg got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", hi, lo); else passed++;
        checks++; if (lat !== 33) $display("FAIL div_latency got %0d exp 33", lat); else passed++;
        model_op(OP_DIV, 32'd5, 32'd0, eh, el, edz, el_n);
        run_op(OP_DIV, 32'd5, 32'd0, hi, lo, dz, lat, bn);
        checks++; if (lat !== 0) $display("FAIL divzero_latency got %0d exp 0", lat); else passed++;
        checks++; if (dz !== 1'b1) $display("FAIL divzero_flag got %b exp 1", dz); else passed++;
        checks++; if (bn !== 0) $display("FAIL divzero_busy got %0d exp 0", bn); else passed++;
        checks++; if (hi !== 32'd5 || lo !== 32'hFFFFFFFF) $display("FAIL divzero_hilo got hi=%h lo=%h exp hi=5 lo=ffffffff", hi, lo); else passed++;
        @(negedge Clk);
        checks++; if (bus.DivByZero !== 1'b0 || bus.Done !== 1'b0) $display("FAIL divzero_pulse got dz=%b done=%b exp 0 0", bus.DivByZero, bus.Done); else passed++;
        model_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, eh, el, edz, el_n);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, hi, lo, dz, lat, bn);
        checks++; if (lo !== 32'h80000000 || hi !== 32'h0 || dz !== 1'b0) $display("FAIL div_ovf got hi=%h lo=%h dz=%b exp hi=0 lo=80000000 dz=0", hi, lo, dz); else passed++;
    endtask

    task automatic test_madd_msub();
        logic [W-1:0] hi, lo, eh, el; logic dz, edz; int lat, bn, el_n;
        model_op(OP_MTLO, 32'hFFFFFFFF, 32'd0, eh, el, edz, el_n);
        run_op(OP_MTLO, 32'hFFFFFFFF, 32'd0, hi, lo, dz, lat, bn);
        checks++; if (lat !== 0 || bn !== 0 || lo !== 32'hFFFFFFFF) $display("FAIL mtlo got lat=%0d busy=%0d lo=%h exp 0 0 ffffffff", lat, bn, lo); else passed++;
        model_op(OP_MTHI, 32'd0, 32'd0, eh, el, edz, el_n);
        run_op(OP_MTHI, 32'd0, 32'd0, hi, lo, dz, lat, bn);
        checks++; if (hi !== 32'd0) $display("FAIL mthi got %h exp 0", hi); else passed++;
        model_op(OP_MADD, 32'd1, 32'd1, eh, el, edz, el_n);
        run_op(OP_MADD, 32'd1, 32'd1, hi, lo, dz, lat, bn);
        checks++; if (hi !== 32'd1 || lo !== 32'd0) $display("FAIL madd got hi=%h lo=%h exp hi=1 lo=0", hi, lo); else passed++;
        model_op(OP_MSUB, 32'd1, 32'd1, eh, el, edz, el_n);
        run_op(OP_MSUB, 32'd1, 32'd1, hi, lo, dz, lat, bn);
        checks++; if (hi !== 32'd0 || lo !== 32'hFFFFFFFF) $display("FAIL msub got hi=%h lo=%h exp hi=0 lo=ffffffff", hi, lo); else passed++;
    endtask

    // Back-to-back by construction: each op is issued in the prior Done cycle
    // unless a random gap is inserted.
    task automatic test_random();
        logic [W-1:0] hi, lo, eh, el, a, b; logic [2:0] op; logic dz, edz; int lat, bn, el_n;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : pick();
            model_op(op, a, b, eh, el, edz, el_n);
            run_op(op, a, b, hi, lo, dz, lat, bn);
            checks++;
            if (hi !== eh || lo !== el || dz !== edz || lat !== el_n || bn !== el_n)
                $display("FAIL rand_%0d op=%0d a=%h b=%h got hi=%h lo=%h dz=%b lat=%0d busy=%0d exp hi=%h lo=%h dz=%b lat=%0d",
                         i, op, a, b, hi, lo, dz, lat, bn, eh, el, edz, el_n);
            else passed++;
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end
    endtask

    task automatic test_busy_flush();
        logic [W-1:0] hi, lo, eh, el; logic dz, edz; int lat, bn, el_n, dones;
        // MULT, a Start while Busy, then Flush ~10 cycles in.
        bus.Start = 1'b1; bus.Op = OP_MULT; bus.OperandA = $urandom; bus.OperandB = $urandom;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (2) @(negedge Clk);
        bus.Start = 1'b1; bus.Op = OP_MTHI; bus.OperandA = 32'hDEADBEEF;
        @(negedge Clk);
        bus.Start = 1'b0;
        checks++; if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) $display("FAIL busy_start got busy=%b done=%b exp 1 0", bus.Busy, bus.Done); else passed++;
        repeat (6) @(negedge Clk);
        bus.Flush = 1'b1;
        @(negedge Clk);
        bus.Flush = 1'b0;
        checks++; if (bus.Busy !== 1'b0) $display("FAIL flush_busy got %b exp 0", bus.Busy); else passed++;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.Done === 1'b1) dones++;
            @(negedge Clk);
        end
        checks++; if (dones !== 0) $display("FAIL flush_done got %0d pulses exp 0", dones); else passed++;
        checks++; if (bus.Hi !== m_hi || bus.Lo !== m_lo) $display("FAIL flush_hilo got hi=%h lo=%h exp hi=%h lo=%h", bus.Hi, bus.Lo, m_hi, m_lo); else passed++;
        // Flush during the final fix cycle.
        bus.Start = 1'b1; bus.Op = OP_DIVU; bus.OperandA = $urandom; bus.OperandB = 32'd3;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (W) @(negedge Clk);
        bus.Flush = 1'b1;
        @(negedge Clk);
        bus.Flush = 1'b0;
        checks++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) $display("FAIL flush_fix got busy=%b done=%b exp 0 0", bus.Busy, bus.Done); else passed++;
        checks++; if (bus.Hi !== m_hi || bus.Lo !== m_lo) $display("FAIL flush_fix_hilo got hi=%h lo=%h exp hi=%h lo=%h", bus.Hi, bus.Lo, m_hi, m_lo); else passed++;
        // Flush beats Start in idle.
        bus.Start = 1'b1; bus.Flush = 1'b1; bus.Op = OP_MTHI; bus.OperandA = 32'h12345678;
        @(negedge Clk);
        bus.Start = 1'b0; bus.Flush = 1'b0;
        checks++; if (bus.Done !== 1'b0 || bus.Hi !== m_hi) $display("FAIL flush_start_mthi got done=%b hi=%h exp 0 %h", bus.Done, bus.Hi, m_hi); else passed++;
        bus.Start = 1'b1; bus.Flush = 1'b1; bus.Op = OP_MULT; bus.OperandA = 32'd9;
        @(negedge Clk);
        bus.Start = 1'b0; bus.Flush = 1'b0;
        checks++; if (bus.Busy !== 1'b0) $display("FAIL flush_start_mult got busy=%b exp 0", bus.Busy); else passed++;
        // Unit still operates after aborts.
        model_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, eh, el, edz, el_n);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, hi, lo, dz, lat, bn);
        checks++; if (hi !== eh || lo !== el || lat !== el_n) $display("FAIL post_flush got hi=%h lo=%h lat=%0d exp hi=%h lo=%h lat=%0d", hi, lo, lat, eh, el, el_n); else passed++;
    endtask

    task automatic test_reset_mid_div();
        logic [W-1:0] hi, lo, eh, el; logic dz, edz; int lat, bn, el_n;
        model_op(OP_MTHI, 32'hA5A5A5A5, 32'd0, eh, el, edz, el_n);
        run_op(OP_MTHI, 32'hA5A5A5A5, 32'd0, hi, lo, dz, lat, bn);
        model_op(OP_MTLO, 32'h5A5A5A5A, 32'd0, eh, el, edz, el_n);
        run_op(OP_MTLO, 32'h5A5A5A5A, 32'd0, hi, lo, dz, lat, bn);
        bus.Start = 1'b1; bus.Op = OP_DIV; bus.OperandA = 32'd1000; bus.OperandB = 32'd3;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (5) @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        checks++; if (bus.Busy !== 1'b0) $display("FAIL async_rst_busy got %b exp 0", bus.Busy); else passed++;
        checks++; if (bus.Done !== 1'b0 || bus.DivByZero !== 1'b0) $display("FAIL async_rst_flags got done=%b dz=%b exp 0 0", bus.Done, bus.DivByZero); else passed++;
        checks++; if (bus.Hi !== 32'h0 || bus.Lo !== 32'h0) $display("FAIL async_rst_hilo got hi=%h lo=%h exp 0 0", bus.Hi, bus.Lo); else passed++;
        @(negedge Clk);
        Reset = 1'b1;
        m_hi = '0; m_lo = '0;
        model_op(OP_DIV, 32'hFFFFFC18, 32'd7, eh, el, edz, el_n);
        run_op(OP_DIV, 32'hFFFFFC18, 32'd7, hi, lo, dz, lat, bn);
        checks++; if (hi !== eh || lo !== el || lat !== 33) $display("FAIL post_reset_div got hi=%h lo=%h lat=%0d exp hi=%h lo=%h lat=33", hi, lo, lat, eh, el); else passed++;
    endtask

    initial begin
        Reset = 1'b0;
        bus.Start = 1'b0; bus.Op = 3'b0; bus.OperandA = '0; bus.OperandB = '0; bus.Flush = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_madd_msub();
        test_random();
        test_busy_flush();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hi_lo_muldiv_unit.md
HI_LO_MULDIV_UNIT -- requirements
Module: hi_lo_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and Hi/Lo register width (even, >= 8).
REQ-002 SHALL have port Clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port Start  in  1  request a new operation; sampled only while Busy=0.
REQ-005 SHALL have port Op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB, 110 MTHI, 111 MTLO.
REQ-006 SHALL have port OperandA  in  WIDTH  rs value; dividend / multiplicand / MTHI/MTLO source.
REQ-007 SHALL have port OperandB  in  WIDTH  rt value; divisor / multiplier.
REQ-008 SHALL have port Flush  in  1  abort any in-flight operation.
REQ-009 SHALL have port Busy  out  1  iterative operation in progress.
REQ-010 SHALL have port Done  out  1  one-cycle pulse: Hi/Lo just updated.
REQ-011 SHALL have port DivByZero  out  1  one-cycle pulse, coincident with Done, for DIV/DIVU with OperandB=0.
REQ-012 SHALL have ports Hi and Lo  out  WIDTH each  architectural Hi/Lo registers.

Function
REQ-013 SHALL implement states IDLE, RUN, FIX; IDLE->RUN on accepted MULT/MULTU/DIV/DIVU/MADD/MSUB; RUN->FIX when iteration counter reaches 0; FIX->IDLE unconditionally.
REQ-014 SHALL capture Op, OperandA, OperandB at the accepting edge; later input changes have no effect.
REQ-015 SHALL run WIDTH RUN cycles (radix-2 shift-add multiply, restoring divide on magnitudes); FIX applies sign correction and writes Hi/Lo.
REQ-016 SHALL hold Busy high for exactly WIDTH+1 cycles after the accepting edge (RUN and FIX); Done high in the cycle after FIX; result latency WIDTH+1 cycles (33 at WIDTH=32).
REQ-017 SHALL produce MULT/MULTU: {Hi,Lo} = full 2*WIDTH-bit signed/unsigned product.
REQ-018 SHALL produce MADD/MSUB: {Hi,Lo} = {Hi,Lo} +/- signed product, modulo 2^(2*WIDTH); Hi/Lo read at FIX.
REQ-019 SHALL produce DIV/DIVU: Lo = quotient truncated toward zero, Hi = remainder with sign of dividend (DIV).
REQ-020 SHALL give DIV of most-negative by -1: Lo = most-negative value, Hi = 0, no flag.
REQ-021 SHALL complete DIV/DIVU with OperandB=0 without entering RUN: Hi = OperandA, Lo = all ones, Done and DivByZero pulse the cycle after acceptance, Busy never asserted.
REQ-022 SHALL complete MTHI/MTLO in one cycle: Hi (or Lo) = OperandA at the accepting edge, Done pulses next cycle, Busy never asserted.
REQ-023 SHALL ignore Start while Busy=1 (no queueing; requester must stall).
REQ-024 SHALL on Flush in RUN/FIX: return to IDLE next edge, Hi/Lo unchanged, no Done/DivByZero.
REQ-025 SHALL give Flush priority over a simultaneous Start in IDLE (Start discarded).
REQ-026 SHALL accept a new Start in the same cycle Done is high.

Reset
REQ-027 SHALL, while Reset=0, force Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, state IDLE, counter 0, independent of Clk.
REQ-028 SHALL discard any in-flight operation on reset; first Start is accepted at the first rising edge after Reset rises.

Structure
REQ-029 SHALL place Op encodings, state encoding, and default WIDTH in shared package hi_lo_pkg.
REQ-030 SHALL split the shift/add/subtract datapath into one sub-module hi_lo_iter_core; control FSM, counter, Hi/Lo registers stay in the top.

Verification (WIDTH=32)
REQ-031 SHALL cover MULT A=0xFFFFFFFD (-3), B=7 -> after 33 cycles Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, Done for one cycle.
REQ-032 SHALL cover DIVU 100/7 -> Lo=14, Hi=2; DIV 0xFFFFFFF9 (-7)/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-033 SHALL cover DIV A=5, B=0 -> next cycle Done=DivByZero=1, Hi=5, Lo=0xFFFFFFFF, Busy stays 0.
REQ-034 SHALL cover MTLO 0xFFFFFFFF, MTHI 0, then MADD A=1, B=1 -> Hi=1, Lo=0; then MSUB A=1, B=1 -> Hi=0, Lo=0xFFFFFFFF.
REQ-035 SHALL cover Flush 10 cycles into MULT, plus Start while Busy -> Busy low next cycle, Hi/Lo unchanged, no Done, busy-time Start ignored.
REQ-036 SHALL cover Reset low mid-DIV -> all outputs 0 immediately without a clock edge; Start after release completes normally.
